// File: rtl/mux_rr_arbiter_pkg.sv
// Shared sizes and state encoding for the round-robin operand-bus arbiter.
package mux_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching from ptr upward, mod 4.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] Req,
  input  logic [SEL_W-1:0]   Ptr,
  output logic [SEL_W-1:0]   pick,
  output logic               any
);

  logic [SEL_W-1:0] idx;

  // Walk the offsets from the far end so the nearest hit to Ptr is written last.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = Ptr + SEL_W'(i);
      if (Req[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4-input operand mux, with a registered output.
// Optional owner preemption after MAX_HOLD cycles is compiled in with MUX_ARB_HOLD_LIMIT_EN.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] Req,
  input  logic [DATA_W-1:0]  A,
  input  logic [DATA_W-1:0]  B,
  input  logic [DATA_W-1:0]  C,
  input  logic [DATA_W-1:0]  D,
  output logic [NUM_REQ-1:0] Grant,
  output logic [SEL_W-1:0]   Sel,
  output logic [DATA_W-1:0]  Y_out,
  output logic               Valid
);

  if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
    $error("mux_rr_arbiter: MAX_HOLD must be in 2..255");
  end

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]  y_q, y_d;
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  opnd;
  logic [SEL_W-1:0]   pick;
  logic               any;
  logic               rel;

`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam int unsigned HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

  rr_pick u_pick (
    .Req  (Req),
    .Ptr  (ptr_q),
    .pick (pick),
    .any  (any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    y_d     = y_q;
    valid_d = 1'b0;
    rel     = 1'b0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    hold_cnt_d = hold_cnt_q;
`endif

    case (sel_q)
      2'd0:    opnd = A;
      2'd1:    opnd = B;
      2'd2:    opnd = C;
      default: opnd = D;
    endcase

    case (state_q)
      IDLE: begin
        if (any) begin
          state_d       = GRANT;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          sel_d         = pick;
`ifdef MUX_ARB_HOLD_LIMIT_EN
          hold_cnt_d    = '0;
`endif
        end
      end
      default: begin
        y_d     = opnd;
        valid_d = 1'b1;
        rel     = !Req[sel_q];
`ifdef MUX_ARB_HOLD_LIMIT_EN
        // Preempt only when someone else is actually waiting.
        if ((hold_cnt_q == HOLD_LAST) && ((Req & ~grant_q) != '0)) rel = 1'b1;
        if (hold_cnt_q != HOLD_LAST) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
`endif
        if (rel) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = sel_q + SEL_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      sel_q      <= '0;
      ptr_q      <= '0;
      y_q        <= '0;
      valid_q    <= 1'b0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      y_q        <= y_d;
      valid_q    <= valid_d;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign Grant = grant_q;
  assign Sel   = sel_q;
  assign Y_out = y_q;
  assign Valid = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (MAX_HOLD=4); follows MUX_ARB_HOLD_LIMIT_EN.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Req;
  logic [3:0] A, B, C, D;
  logic [3:0] Grant;
  logic [1:0] Sel;
  logic [3:0] Y_out;
  logic       Valid;

  int n_checks = 0;
  int n_errors = 0;

  mux_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .Req   (Req),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .Grant (Grant),
    .Sel   (Sel),
    .Y_out (Y_out),
    .Valid (Valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {Grant, Sel, Y_out, Valid} packed for compact checks
  function automatic logic [31:0] outs();
    return {21'd0, Grant, Sel, Y_out, Valid};
  endfunction

  function automatic logic [31:0] pk(input logic [3:0] g, input logic [1:0] s,
                                     input logic [3:0] y, input logic v);
    return {21'd0, g, s, y, v};
  endfunction

  initial begin
    int seq [5];
    seq = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    Req = 4'b1111;
    A = 4'h1; B = 4'h2; C = 4'hA; D = 4'h4;
    #1;

    // Reset held 3 cycles with all requests up
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", outs(), pk(4'b0000, 2'b00, 4'h0, 1'b0));
    end
    reset = 1'b0;
    Req = 4'b0000;
    tick();
    chk("reset_after", outs(), pk(4'b0000, 2'b00, 4'h0, 1'b0));

    // Single request from C
    Req = 4'b0100;
    tick();
    chk("single_grant", outs(), pk(4'b0100, 2'b10, 4'h0, 1'b0));
    tick();
    chk("single_data", outs(), pk(4'b0100, 2'b10, 4'hA, 1'b1));
    C = 4'h5;
    tick();
    chk("single_track", outs(), pk(4'b0100, 2'b10, 4'h5, 1'b1));
    Req = 4'b0000;
    tick();
    chk("single_rel1", outs(), pk(4'b0000, 2'b10, 4'h5, 1'b1));
    tick();
    chk("single_rel2", outs(), pk(4'b0000, 2'b10, 4'h5, 1'b0));
    C = 4'hA;

    // Rotation from Ptr=0 with all four requesting
    reset = 1'b1;
    tick();
    reset = 1'b0;
    Req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] oh;
      oh = 4'b0001 << seq[k];
      tick();
      chk("rot_grant", {28'd0, Grant}, {28'd0, oh});
      chk("rot_sel", {30'd0, Sel}, 32'(seq[k]));
      Req = 4'b1111 & ~oh;
      tick();
      chk("rot_idle", {28'd0, Grant}, 32'd0);
      Req = 4'b1111;
    end
    Req = 4'b0000;
    tick();

    // Simultaneous requests 1 and 3 with Ptr=0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    Req = 4'b1010;
    tick();
    chk("simul_first", {28'd0, Grant}, 32'b0010);
    Req = 4'b1000;
    tick();
    chk("simul_idle1", {28'd0, Grant}, 32'd0);
    tick();
    chk("simul_second", {28'd0, Grant}, 32'b1000);
    chk("simul_second_y", {28'd0, Y_out}, 32'h2);
    Req = 4'b0000;
    tick();
    chk("simul_idle2", {28'd0, Grant}, 32'd0);
    Req = 4'b1111;
    tick();
    chk("simul_ptr0", {28'd0, Grant}, 32'b0001);
    Req = 4'b0000;
    tick();
    tick();

    // Hold limit: requester 0 holds, requester 2 arrives during the grant (Ptr=1 here)
    Req = 4'b0001;
    tick();
    chk("hold_c1", {28'd0, Grant}, 32'b0001);
    Req = 4'b0101;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("hold_own", {28'd0, Grant}, 32'b0001);
    end
    tick();
    chk("hold_idle", {28'd0, Grant}, 32'd0);
    tick();
    chk("hold_next", {28'd0, Grant}, 32'b0100);
`else
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk("hold_keep", {28'd0, Grant}, 32'b0001);
    end
`endif
    Req = 4'b0000;
    tick();
    tick();
    chk("hold_done", {31'd0, Valid}, 32'd0);

    // Reset in the middle of a grant to requester 1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    Req = 4'b0010;
    tick();
    tick();
    chk("midrst_pre", outs(), pk(4'b0010, 2'b01, 4'h2, 1'b1));
    reset = 1'b1;
    tick();
    chk("midrst_rst", outs(), pk(4'b0000, 2'b00, 4'h0, 1'b0));
    reset = 1'b0;
    Req = 4'b1111;
    tick();
    chk("midrst_ptr0", {28'd0, Grant}, 32'b0001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

- Round-robin arbiter that shares the 4-bit, 4-input selection datapath among four requesters.
- It grants one requester at a time, drives a one-hot grant and the 2-bit select.
- It registers the selected 4-bit operand onto a shared output with a valid flag.
- It sits between the requesting blocks and the shared operand bus; it owns all sequencing of the select line.

## Interface
Parameters:
- MAX_HOLD, 8: maximum consecutive GRANT cycles per owner when another requester waits (used only with hold limit compiled in); legal range 2..255.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- Req  in  4  request per requester; bit i = requester i (0→A, 1→B, 2→C, 3→D); level-sensitive, held until served.
- A, B, C, D  in  4 each  requester operands.
- Grant  out  4  registered one-hot grant; all-zero when idle.
- Sel  out  2  registered select, encoding of the granted index.
- Y_out  out  4  registered selected operand.
- Valid  out  1  Y_out carries the current owner's operand.

## Operation
- Reset values: Grant=4'b0000, Sel=2'b00, Y_out=4'b0000, Valid=0, Ptr=2'd0, HoldCnt=0, state=IDLE.
- Ptr is the round-robin pointer. Search order is Ptr, Ptr+1, Ptr+2, Ptr+3, all mod 4.
- State IDLE:
  - Req==0: stay in IDLE.
  - Otherwise: pick the first set Req bit in search order.
  - Next cycle: state=GRANT, Grant=onehot(pick), Sel=pick, HoldCnt=0.
- State GRANT (owner = Sel):
  - Req[owner]==0: release. Next cycle state=IDLE, Grant=0, Ptr=owner+1 mod 4. Sel holds its last value.
  - Hold limit (macro defined): HoldCnt==MAX_HOLD-1 and (Req & ~Grant)!=0 forces a release with identical effects.
  - Otherwise: stay in GRANT; HoldCnt increments and saturates at MAX_HOLD-1.
- Every release passes through IDLE, so there is always ≥1 cycle with Grant=0 between owners.
- Y_out/Valid update every cycle:
  - In GRANT: Y_out ← operand[Sel], Valid ← 1.
  - In IDLE: Y_out holds, Valid ← 0.
- Y_out tracks operand changes of the owner with 1-cycle lag while the grant is held.
- Req bits of non-owners never affect Grant during GRANT, except for triggering the hold-limit release.
- Simultaneous requests: resolved purely by Ptr order, with no fixed priority.
- Reset asserted in any state: all registers go to their reset values on that edge, overriding every other transition.

## Timing
- Req rises at edge N (sampled in IDLE) → Grant/Sel valid after edge N+1.
- Y_out=operand and Valid=1 after edge N+2.
- Request-to-grant latency is 1 cycle; request-to-data latency is 2 cycles.
- Release: owner's Req low sampled at edge M → Grant=0 after M+1, Valid=0 after M+2.
- Next grant is no earlier than after M+2.
- Worst-case wait with 4 active requesters, hold limit enabled: 3×(MAX_HOLD+1)+1 cycles.

## Configuration
- MUX_ARB_HOLD_LIMIT_EN defined:
  - HoldCnt register and forced release are present.
  - An owner is preempted after MAX_HOLD GRANT cycles if another Req bit is set.
  - An owner with no contenders keeps the grant indefinitely.
- MUX_ARB_HOLD_LIMIT_EN undefined:
  - No HoldCnt and no preemption; MAX_HOLD is ignored.
  - An owner holds the grant until it drops Req.

## Structure
- Package mux_arb_pkg holds:
  - NUM_REQ=4, DATA_W=4, SEL_W=2.
  - State encoding IDLE=1'b0, GRANT=1'b1.
- Sub-module rr_pick: combinational; inputs Req[3:0] and Ptr[1:0]; outputs pick[1:0] and any. Reused by future arbiters.
- The top module holds the FSM, Ptr, HoldCnt, output registers and the operand selection.

## Test plan
- Reset: hold reset 3 cycles with Req=4'b1111 → Grant=0000, Sel=00, Y_out=0000, Valid=0 throughout and on the first cycle after release.
- Single request: Req=0100, C=4'hA from cycle 0 → Grant=0100 and Sel=10 at cycle 1; Y_out=4'hA and Valid=1 at cycle 2; drop Req → Grant=0 one cycle later, Valid=0 two cycles later.
- Rotation: Req=1111, each requester drops Req one cycle after it sees its grant → grant order 0,1,2,3,0 with one idle cycle between grants.
- Simultaneous: Ptr=0, Req=1010 → grant requester 1 first, then requester 3, then Ptr=0.
- Hold limit: MAX_HOLD=4, Req[0] held, Req[2] raised during the grant:
  - Macro defined: Grant=0001 for exactly 4 cycles, 1 idle cycle, then Grant=0100.
  - Macro undefined: Grant=0001 persists.
- Reset mid-grant: assert reset while Grant=0010 and Valid=1 → all outputs at reset values after that edge; Ptr=0, so the next Req=1111 grants requester 0.
